// File: rtl/vlsu_sequencer.sv
// Vector load/store sequencer: spreads one unit-stride or strided vector access across four
// byte-enabled data-memory ports, serving up to four elements per cycle.
module vlsu_sequencer #(
    parameter int ADDR_WIDTH = 10,
    parameter int VLMAX      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         isStore,
    input  logic [1:0]                   sew,
    input  logic [ADDR_WIDTH-1:0]        baseAddr,
    input  logic [ADDR_WIDTH-1:0]        stride,
    input  logic [$clog2(VLMAX+1)-1:0]   vl,
    input  logic [VLMAX*32-1:0]          storeData,
    output logic                         busy,
    output logic                         done,
    output logic [VLMAX*32-1:0]          loadData,
    output logic [ADDR_WIDTH-1:0]        addr0,
    output logic [ADDR_WIDTH-1:0]        addr1,
    output logic [ADDR_WIDTH-1:0]        addr2,
    output logic [ADDR_WIDTH-1:0]        addr3,
    output logic [2:0]                   writeEnable0,
    output logic [2:0]                   writeEnable1,
    output logic [2:0]                   writeEnable2,
    output logic [2:0]                   writeEnable3,
    output logic [31:0]                  writeData0,
    output logic [31:0]                  writeData1,
    output logic [31:0]                  writeData2,
    output logic [31:0]                  writeData3,
    output logic [2:0]                   readEnable0,
    output logic [2:0]                   readEnable1,
    output logic [2:0]                   readEnable2,
    output logic [2:0]                   readEnable3,
    input  logic [31:0]                  readData0,
    input  logic [31:0]                  readData1,
    input  logic [31:0]                  readData2,
    input  logic [31:0]                  readData3
);
    localparam int VLW = $clog2(VLMAX + 1);
    localparam int IW  = VLW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

    state_t                  state_r;
    logic [IW-1:0]           idx_r;
    logic                    is_store_r;
    logic [1:0]              sew_r;
    logic [ADDR_WIDTH-1:0]   base_r;
    logic [ADDR_WIDTH-1:0]   stride_r;
    logic [VLW-1:0]          vl_r;
    logic [VLMAX*32-1:0]     data_r;
    logic                    busy_r;
    logic                    done_r;
    logic [VLMAX*32-1:0]     load_r;
    logic [ADDR_WIDTH-1:0]   addr_r [4];
    logic [2:0]              we_r [4];
    logic [2:0]              re_r [4];
    logic [31:0]             wd_r [4];

    logic                    accept_s;
    logic [VLW-1:0]          vl_clamp_s;
    logic                    src_store_s;
    logic [1:0]              src_sew_s;
    logic [ADDR_WIDTH-1:0]   src_base_s;
    logic [ADDR_WIDTH-1:0]   src_stride_s;
    logic [VLW-1:0]          src_vl_s;
    logic [VLMAX*32-1:0]     src_data_s;
    logic [IW-1:0]           nidx_s;
    logic                    drive_s;
    logic [IW-1:0]           elem_s [4];
    logic [ADDR_WIDTH-1:0]   n_addr_s [4];
    logic [2:0]              n_we_s [4];
    logic [2:0]              n_re_s [4];
    logic [31:0]             n_wd_s [4];
    logic [31:0]             rd_s [4];

    function automatic logic [2:0] en_code(input logic [1:0] s);
        case (s)
            2'd0:    en_code = 3'b001;
            2'd1:    en_code = 3'b011;
            default: en_code = 3'b111;
        endcase
    endfunction

    function automatic logic [31:0] sew_mask(input logic [1:0] s);
        case (s)
            2'd0:    sew_mask = 32'h0000_00FF;
            2'd1:    sew_mask = 32'h0000_FFFF;
            default: sew_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    assign rd_s[0] = readData0;
    assign rd_s[1] = readData1;
    assign rd_s[2] = readData2;
    assign rd_s[3] = readData3;

    // Next port drive: the accept edge launches group 0 from the live inputs, later edges
    // launch the following group from the snapshot.
    always_comb begin
        accept_s   = (state_r == IDLE) && start;
        vl_clamp_s = (vl > VLW'(VLMAX)) ? VLW'(VLMAX) : vl;
        if (accept_s) begin
            src_store_s  = isStore;
            src_sew_s    = sew;
            src_base_s   = baseAddr;
            src_stride_s = stride;
            src_vl_s     = vl_clamp_s;
            src_data_s   = storeData;
            nidx_s       = '0;
            drive_s      = (vl_clamp_s != '0);
        end else begin
            src_store_s  = is_store_r;
            src_sew_s    = sew_r;
            src_base_s   = base_r;
            src_stride_s = stride_r;
            src_vl_s     = vl_r;
            src_data_s   = data_r;
            nidx_s       = idx_r + IW'(4);
            drive_s      = (state_r == ISSUE) && (nidx_s < IW'(vl_r));
        end
        for (int p = 0; p < 4; p++) begin
            elem_s[p] = nidx_s + IW'(p);
            if (drive_s && (elem_s[p] < IW'(src_vl_s))) begin
                n_addr_s[p] = src_base_s + ADDR_WIDTH'(elem_s[p]) * src_stride_s;
                n_we_s[p]   = src_store_s ? en_code(src_sew_s) : 3'b000;
                n_re_s[p]   = src_store_s ? 3'b000 : en_code(src_sew_s);
                n_wd_s[p]   = src_store_s ? src_data_s[32*elem_s[p] +: 32] : 32'h0;
            end else begin
                n_addr_s[p] = '0;
                n_we_s[p]   = 3'b000;
                n_re_s[p]   = 3'b000;
                n_wd_s[p]   = 32'h0;
            end
        end
    end

    // Sequencer state, operand snapshot, load gathering and registered port outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            is_store_r <= 1'b0;
            sew_r      <= 2'd0;
            base_r     <= '0;
            stride_r   <= '0;
            vl_r       <= '0;
            data_r     <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            load_r     <= '0;
            for (int p = 0; p < 4; p++) begin
                addr_r[p] <= '0;
                we_r[p]   <= 3'b000;
                re_r[p]   <= 3'b000;
                wd_r[p]   <= 32'h0;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                addr_r[p] <= n_addr_s[p];
                we_r[p]   <= n_we_s[p];
                re_r[p]   <= n_re_s[p];
                wd_r[p]   <= n_wd_s[p];
            end
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        is_store_r <= isStore;
                        sew_r      <= sew;
                        base_r     <= baseAddr;
                        stride_r   <= stride;
                        vl_r       <= vl_clamp_s;
                        data_r     <= storeData;
                        idx_r      <= '0;
                        busy_r     <= 1'b1;
                        if (!isStore) begin
                            load_r <= '0;
                        end
                        state_r <= (vl_clamp_s == '0) ? DONE : ISSUE;
                        done_r  <= (vl_clamp_s == '0);
                    end
                end
                ISSUE: begin
                    // Read data of the group on the ports right now is captured at this edge.
                    for (int p = 0; p < 4; p++) begin
                        if (re_r[p] != 3'b000) begin
                            load_r[32*(idx_r + IW'(p)) +: 32] <= rd_s[p] & sew_mask(sew_r);
                        end
                    end
                    if ((idx_r + IW'(4)) >= IW'(vl_r)) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IW'(4);
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign loadData     = load_r;
    assign addr0        = addr_r[0];
    assign addr1        = addr_r[1];
    assign addr2        = addr_r[2];
    assign addr3        = addr_r[3];
    assign writeEnable0 = we_r[0];
    assign writeEnable1 = we_r[1];
    assign writeEnable2 = we_r[2];
    assign writeEnable3 = we_r[3];
    assign writeData0   = wd_r[0];
    assign writeData1   = wd_r[1];
    assign writeData2   = wd_r[2];
    assign writeData3   = wd_r[3];
    assign readEnable0  = re_r[0];
    assign readEnable1  = re_r[1];
    assign readEnable2  = re_r[2];
    assign readEnable3  = re_r[3];

endmodule

// File: tb/tb_vlsu_sequencer.sv
// Bench for vlsu_sequencer: byte-array memory on the four ports, element-level reference
// model for addresses, enables, gathered loads and final memory image.
module tb_vlsu_sequencer;
    localparam int AW    = 10;
    localparam int VLMAX = 8;
    localparam int VLW   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, start, isStore;
    logic [1:0]           sew;
    logic [AW-1:0]        baseAddr, stride;
    logic [VLW-1:0]       vl;
    logic [VLMAX*32-1:0]  storeData;
    logic                 busy, done;
    logic [VLMAX*32-1:0]  loadData;
    logic [AW-1:0]        addr [4];
    logic [2:0]           we [4];
    logic [2:0]           re [4];
    logic [31:0]          wd [4];
    logic [31:0]          rd [4];

    logic [7:0]           mem [1024];
    logic [7:0]           mem_img [1024];
    logic [7:0]           exp_mem [1024];
    logic                 mem_load;
    logic [VLMAX*32-1:0]  last_ld;

    int n_assert = 0;
    int n_fail   = 0;

    vlsu_sequencer #(.ADDR_WIDTH(AW), .VLMAX(VLMAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .isStore(isStore), .sew(sew),
        .baseAddr(baseAddr), .stride(stride), .vl(vl), .storeData(storeData),
        .busy(busy), .done(done), .loadData(loadData),
        .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]), .addr3(addr[3]),
        .writeEnable0(we[0]), .writeEnable1(we[1]), .writeEnable2(we[2]), .writeEnable3(we[3]),
        .writeData0(wd[0]), .writeData1(wd[1]), .writeData2(wd[2]), .writeData3(wd[3]),
        .readEnable0(re[0]), .readEnable1(re[1]), .readEnable2(re[2]), .readEnable3(re[3]),
        .readData0(rd[0]), .readData1(rd[1]), .readData2(rd[2]), .readData3(rd[3])
    );

    // Combinational memory read, disabled bytes return zero.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            rd[p] = 32'h0;
            if (re[p][0]) rd[p][7:0]   = mem[addr[p]];
            if (re[p][1]) rd[p][15:8]  = mem[addr[p] + 10'd1];
            if (re[p][2]) rd[p][31:16] = {mem[addr[p] + 10'd3], mem[addr[p] + 10'd2]};
        end
    end

    // Memory writes, port 3 applied last; image load used only for initialisation.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= mem_img[i];
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (we[p][0]) mem[addr[p]] <= wd[p][7:0];
                if (we[p][1]) mem[addr[p] + 10'd1] <= wd[p][15:8];
                if (we[p][2]) begin
                    mem[addr[p] + 10'd2] <= wd[p][23:16];
                    mem[addr[p] + 10'd3] <= wd[p][31:24];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] code_of(input logic [1:0] s);
        return (s == 2'd0) ? 3'b001 : (s == 2'd1) ? 3'b011 : 3'b111;
    endfunction

    task automatic chk_mem();
        int diff = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) diff++;
        chk("mem_image", diff, 0);
    endtask

    task automatic run_op(input bit st, input logic [1:0] s, input logic [AW-1:0] b,
                          input logic [AW-1:0] strd, input logic [VLW-1:0] v,
                          input logic [255:0] d, input bit poke);
        int vlc, n;
        logic [AW-1:0] a;
        logic [255:0] exp_ld;
        vlc = (v > 4'd8) ? 8 : int'(v);
        n   = (vlc + 3) / 4;
        exp_ld = last_ld;
        if (!st) exp_ld = '0;
        for (int e = 0; e < vlc; e++) begin
            a = b + AW'(e) * strd;
            if (st) begin
                exp_mem[a] = d[32*e +: 8];
                if (s >= 2'd1) exp_mem[a + 10'd1] = d[32*e+8 +: 8];
                if (s >= 2'd2) begin
                    exp_mem[a + 10'd2] = d[32*e+16 +: 8];
                    exp_mem[a + 10'd3] = d[32*e+24 +: 8];
                end
            end else begin
                exp_ld[32*e +: 8] = exp_mem[a];
                if (s >= 2'd1) exp_ld[32*e+8 +: 8] = exp_mem[a + 10'd1];
                if (s >= 2'd2) exp_ld[32*e+16 +: 16] = {exp_mem[a + 10'd3], exp_mem[a + 10'd2]};
            end
        end
        @(negedge clk);
        start = 1'b1; isStore = st; sew = s; baseAddr = b; stride = strd; vl = v; storeData = d;
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            if (c == 0 && poke) begin
                start = 1'b1; isStore = ~st; sew = ~s; baseAddr = ~b; stride = ~strd;
                vl = 4'd8; storeData = ~d;
            end else begin
                start = 1'b0;
            end
            chk("busy_during_op", busy, 1'b1);
            chk("done_timing", done, (c == n));
            for (int p = 0; p < 4; p++) begin
                int e;
                e = 4 * c + p;
                if (c < n && e < vlc) begin
                    a = b + AW'(e) * strd;
                    chk("addr", addr[p], a);
                    chk("write_enable", we[p], st ? code_of(s) : 3'b000);
                    chk("read_enable", re[p], st ? 3'b000 : code_of(s));
                    if (st) chk("write_data", wd[p], d[32*e +: 32]);
                end else begin
                    chk("idle_we", we[p], 3'b000);
                    chk("idle_re", re[p], 3'b000);
                end
            end
            if (c == n) chk("load_data", loadData, exp_ld);
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after", busy, 1'b0);
        chk("done_after", done, 1'b0);
        chk_mem();
        last_ld = exp_ld;
    endtask

    initial begin
        logic [255:0] d;
        rst_n = 1'b0; start = 1'b0; isStore = 1'b0; sew = 2'd0; baseAddr = '0; stride = '0;
        vl = '0; storeData = '0; mem_load = 1'b0; last_ld = '0;
        for (int i = 0; i < 1024; i++) mem_img[i] = 8'($urandom);
        for (int i = 0; i < 32; i++) mem_img[16 + i] = 8'(i);
        for (int i = 0; i < 1024; i++) exp_mem[i] = mem_img[i];
        repeat (2) @(negedge clk);
        mem_load = 1'b1;
        @(negedge clk);
        mem_load = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_load", loadData, '0);
        for (int p = 0; p < 4; p++) begin
            chk("rst_addr", addr[p], '0);
            chk("rst_we", we[p], 3'b000);
            chk("rst_re", re[p], 3'b000);
            chk("rst_wd", wd[p], 32'h0);
        end
        rst_n = 1'b1;

        run_op(1'b0, 2'd2, 10'h010, 10'd4, 4'd8, '0, 1'b0);
        chk("elem0", loadData[31:0], 32'h0302_0100);
        chk("elem7", loadData[255:224], 32'h1F1E_1D1C);

        d = '0;
        for (int i = 0; i < 5; i++) d[32*i +: 32] = 32'hA0 + 32'(i);
        run_op(1'b1, 2'd0, 10'h040, 10'd1, 4'd5, d, 1'b0);
        run_op(1'b0, 2'd1, 10'h3FE, 10'd2, 4'd3, '0, 1'b0);

        d = '0;
        for (int i = 0; i < 4; i++) d[32*i +: 32] = 32'(i + 1);
        run_op(1'b1, 2'd2, 10'h080, 10'd0, 4'd4, d, 1'b0);
        chk("stride0_word", {mem[10'h083], mem[10'h082], mem[10'h081], mem[10'h080]}, 32'd4);

        run_op(1'b0, 2'd2, 10'h100, 10'd4, 4'd0, '0, 1'b0);
        run_op(1'b0, 2'd3, 10'h200, 10'h3FC, 4'd12, '0, 1'b0);
        d = {8{$urandom}};
        run_op(1'b1, 2'd2, 10'h300, 10'd8, 4'd8, d, 1'b1);

        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
            run_op(1'($urandom), 2'($urandom), 10'($urandom), 10'($urandom),
                   4'($urandom_range(0, 12)), d, ($urandom_range(0, 3) == 0));
        end

        // Reset at the edge that would launch the second group of an 8-element store.
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        @(negedge clk);
        start = 1'b1; isStore = 1'b1; sew = 2'd2; baseAddr = 10'h1C0; stride = 10'd4;
        vl = 4'd8; storeData = d;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        for (int e = 0; e < 4; e++)
            for (int j = 0; j < 4; j++) exp_mem[10'h1C0 + 10'(4 * e + j)] = d[32*e+8*j +: 8];
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_load", loadData, '0);
        for (int p = 0; p < 4; p++) begin
            chk("abort_addr", addr[p], '0);
            chk("abort_we", we[p], 3'b000);
            chk("abort_wd", wd[p], 32'h0);
        end
        rst_n = 1'b1;
        last_ld = '0;
        repeat (2) @(negedge clk);
        chk_mem();
        run_op(1'b0, 2'd2, 10'h1C0, 10'd4, 4'd8, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
